// File: rtl/pool2x2_stream.sv
// Streaming 2x2 pooling (max or floor-average) over signed multi-channel pixels.
// Horizontal pairs are reduced on the fly; even-row results wait in a line buffer.
module pool2x2_stream #(
  parameter int CH    = 8,
  parameter int DW    = 8,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pool_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH*DW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH*DW-1:0] out_data,
  output logic             frame_done
);

  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int AW  = (IMG_W / 2 > 1) ? $clog2(IMG_W / 2) : 1;
  localparam int LDP = 1 << AW;
  localparam int HW  = CH * (DW + 1);

  typedef enum logic {EVEN_ROW, ODD_ROW} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic             mode_q, mode_d;
  logic             out_valid_q, out_valid_d;
  logic             last_q, last_d;
  logic [CH*DW-1:0] out_data_q, out_data_d;
  logic [CH*DW-1:0] hold_q;
  logic [HW-1:0]    lb_q [LDP];
  logic [HW-1:0]    lb_rd, h_vec;
  logic [CH*DW-1:0] res_vec;
  logic [AW-1:0]    lb_idx;
  logic             accept, col_last, row_last, col_odd, odd_row, load;

  assign in_ready   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign col_last   = (col_q == CW'(IMG_W - 1));
  assign row_last   = (row_q == RW'(IMG_H - 1));
  assign col_odd    = col_q[0];
  assign lb_idx     = AW'(col_q >> 1);
  assign lb_rd      = lb_q[lb_idx];
  assign load       = accept && odd_row && col_odd;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = out_valid_q && out_ready && last_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= EVEN_ROW;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept && col_last) state_d = (state_q == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
  end

  always_comb begin
    odd_row = (state_q == ODD_ROW);
  end

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    mode_d = mode_q;
    if (accept) begin
      col_d = col_last ? '0 : col_q + CW'(1);
      if (col_last) row_d = row_last ? '0 : row_q + RW'(1);
      if (col_q == '0 && row_q == '0) mode_d = pool_mode;
    end
  end

  always_comb begin
    out_valid_d = load || (out_valid_q && !out_ready);
    out_data_d  = load ? res_vec : out_data_q;
    last_d      = load ? (row_last && col_last) : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      last_q      <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      last_q      <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !col_odd) hold_q <= in_data;
    if (accept && col_odd && !odd_row) lb_q[lb_idx] <= h_vec;
  end

  // Max mode keeps h sign-extended, so its low DW bits are the true horizontal max.
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic signed [DW-1:0] a, b, m, hm, lm, vm;
    logic signed [DW:0]   hs, h, l;
    logic signed [DW+1:0] vs;

    assign a  = hold_q[c*DW +: DW];
    assign b  = in_data[c*DW +: DW];
    assign m  = (a > b) ? a : b;
    assign hs = {a[DW-1], a} + {b[DW-1], b};
    assign h  = mode_q ? hs : {m[DW-1], m};
    assign h_vec[c*(DW+1) +: DW+1] = h;

    assign l  = lb_rd[c*(DW+1) +: DW+1];
    assign hm = h[DW-1:0];
    assign lm = l[DW-1:0];
    assign vm = (hm > lm) ? hm : lm;
    assign vs = {h[DW], h} + {l[DW], l};
    assign res_vec[c*DW +: DW] = mode_q ? DW'(vs >>> 2) : vm;
  end

endmodule

// File: tb/tb_pool2x2_stream.sv
// Self-checking bench for pool2x2_stream: table vectors, stall/reset sequences,
// and a randomized multi-frame run against a whole-frame arithmetic model.
module tb_pool2x2_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  // Reference: pool four pixels, each with ch signed 8-bit channels.
  function automatic logic [63:0] pool_px(input logic [63:0] p0, input logic [63:0] p1,
                                          input logic [63:0] p2, input logic [63:0] p3,
                                          input bit avg, input int ch);
    logic [63:0] r;
    logic signed [7:0] t0, t1, t2, t3;
    int s, mx, res;
    r = '0;
    for (int c = 0; c < ch; c++) begin
      t0 = p0[c*8 +: 8];
      t1 = p1[c*8 +: 8];
      t2 = p2[c*8 +: 8];
      t3 = p3[c*8 +: 8];
      s  = int'(t0) + int'(t1) + int'(t2) + int'(t3);
      mx = int'(t0);
      if (int'(t1) > mx) mx = int'(t1);
      if (int'(t2) > mx) mx = int'(t2);
      if (int'(t3) > mx) mx = int'(t3);
      if (avg) res = (s >= 0) ? s / 4 : -((-s + 3) / 4);
      else     res = mx;
      r[c*8 +: 8] = 8'(res);
    end
    return r;
  endfunction

  // DUT S: CH=1, 2x2
  logic s_mode, s_iv, s_ir, s_ov, s_or, s_fd;
  logic [7:0] s_id, s_od;
  pool2x2_stream #(.CH(1), .DW(8), .IMG_W(2), .IMG_H(2)) u_s (
    .clk(clk), .rst(rst), .pool_mode(s_mode), .in_valid(s_iv), .in_ready(s_ir),
    .in_data(s_id), .out_valid(s_ov), .out_ready(s_or), .out_data(s_od), .frame_done(s_fd));

  // DUT M: CH=2, 4x2
  logic m_mode, m_iv, m_ir, m_ov, m_or, m_fd;
  logic [15:0] m_id, m_od;
  pool2x2_stream #(.CH(2), .DW(8), .IMG_W(4), .IMG_H(2)) u_m (
    .clk(clk), .rst(rst), .pool_mode(m_mode), .in_valid(m_iv), .in_ready(m_ir),
    .in_data(m_id), .out_valid(m_ov), .out_ready(m_or), .out_data(m_od), .frame_done(m_fd));

  // DUT R: CH=1, 4x4
  logic r_mode, r_iv, r_ir, r_ov, r_or, r_fd;
  logic [7:0] r_id, r_od;
  pool2x2_stream #(.CH(1), .DW(8), .IMG_W(4), .IMG_H(4)) u_r (
    .clk(clk), .rst(rst), .pool_mode(r_mode), .in_valid(r_iv), .in_ready(r_ir),
    .in_data(r_id), .out_valid(r_ov), .out_ready(r_or), .out_data(r_od), .frame_done(r_fd));

  // DUT L: CH=8, 32x32
  logic l_mode, l_iv, l_ir, l_ov, l_or, l_fd;
  logic [63:0] l_id, l_od;
  pool2x2_stream #(.CH(8), .DW(8), .IMG_W(32), .IMG_H(32)) u_l (
    .clk(clk), .rst(rst), .pool_mode(l_mode), .in_valid(l_iv), .in_ready(l_ir),
    .in_data(l_id), .out_valid(l_ov), .out_ready(l_or), .out_data(l_od), .frame_done(l_fd));

  typedef struct {
    bit avg;
    int p0, p1, p2, p3;
    int exp;
  } vec_t;

  typedef struct packed {
    logic [63:0] d;
    logic        last;
  } exp_t;

  vec_t        tbl [10];
  logic [15:0] m_px [8];
  logic [63:0] m_exp [2];
  logic [7:0]  r_px [16];
  logic [63:0] r_exp [4];
  logic [63:0] l_px [3*1024];
  bit          fm [3];
  exp_t        expq [$];

  initial begin
    int idx, nout, nfd, since, n;
    int p [4];
    logic [7:0] e8;
    exp_t e;

    tbl[0] = '{0, 3, -5, 7, -128, 7};
    tbl[1] = '{1, 3, -5, 7, -128, -31};
    tbl[2] = '{1, 127, 127, 127, 127, 127};
    tbl[3] = '{0, -128, -128, -128, -128, -128};
    tbl[4] = '{1, -128, -128, -128, -128, -128};
    tbl[5] = '{1, -1, 0, 0, 0, -1};
    tbl[6] = '{1, 1, 1, 1, 0, 0};
    tbl[7] = '{0, -1, -2, -3, -4, -1};
    tbl[8] = '{1, 127, 127, 127, 126, 126};
    tbl[9] = '{0, 5, 5, 5, 5, 5};

    {s_mode, s_iv, m_mode, m_iv, r_mode, r_iv, l_mode, l_iv} = '0;
    {s_or, m_or, r_or, l_or} = 4'b1111;
    s_id = '0; m_id = '0; r_id = '0; l_id = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(s_ov), 64'(0));
    chk("rst_out_data", 64'(s_od), 64'(0));
    chk("rst_frame_done", 64'(s_fd), 64'(0));
    chk("rst_in_ready", 64'(s_ir), 64'(1));
    chk("rst_l_out_valid", 64'(l_ov), 64'(0));
    chk("rst_l_in_ready", 64'(l_ir), 64'(1));

    // Table vectors on 2x2; pool_mode flips after the first beat and must be ignored
    for (int i = 0; i < 10; i++) begin
      p[0] = tbl[i].p0; p[1] = tbl[i].p1; p[2] = tbl[i].p2; p[3] = tbl[i].p3;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        s_iv   = 1'b1;
        s_id   = 8'(p[k]);
        s_mode = (k == 0) ? tbl[i].avg : !tbl[i].avg;
      end
      @(negedge clk);
      chk("s_pre_valid", 64'(s_ov), 64'(0));
      @(posedge clk); #1;
      s_iv = 1'b0;
      @(negedge clk);
      e8 = 8'(tbl[i].exp);
      chk("s_valid", 64'(s_ov), 64'(1));
      chk("s_data", 64'(s_od), 64'(e8));
      chk("s_frame_done", 64'(s_fd), 64'(1));
    end

    // Backpressure on 4x2, CH=2, max mode
    for (int i = 0; i < 8; i++) m_px[i] = 16'($urandom);
    m_exp[0] = pool_px(64'(m_px[0]), 64'(m_px[1]), 64'(m_px[4]), 64'(m_px[5]), 1'b0, 2);
    m_exp[1] = pool_px(64'(m_px[2]), 64'(m_px[3]), 64'(m_px[6]), 64'(m_px[7]), 1'b0, 2);
    @(posedge clk); #1;
    m_or = 1'b0;
    idx  = 0;
    for (int cyc = 0; cyc < 40 && idx < 6; cyc++) begin
      @(posedge clk); #1;
      m_iv = 1'b1;
      m_id = m_px[idx];
      @(negedge clk);
      if (m_iv && m_ir) idx++;
    end
    chk("m_fill_done", 64'(idx), 64'(6));
    @(posedge clk); #1;
    m_id = m_px[6];
    @(negedge clk);
    chk("m_first_valid", 64'(m_ov), 64'(1));
    chk("m_first_data", 64'(m_od), m_exp[0]);
    chk("m_stall_ready", 64'(m_ir), 64'(0));
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("m_hold_data", 64'(m_od), m_exp[0]);
      chk("m_hold_ready", 64'(m_ir), 64'(0));
    end
    @(posedge clk); #1;
    m_or = 1'b1;
    nout = 0;
    for (int cyc = 0; cyc < 30 && nout < 2; cyc++) begin
      @(negedge clk);
      if (m_ov && m_or) begin
        chk("m_out", 64'(m_od), m_exp[nout]);
        chk("m_frame_done", 64'(m_fd), 64'(nout == 1));
        nout++;
      end
      if (m_iv && m_ir) idx++;
      @(posedge clk); #1;
      m_iv = (idx < 8);
      if (idx < 8) m_id = m_px[idx];
    end
    chk("m_out_count", 64'(nout), 64'(2));
    m_iv = 1'b0;

    // Mid-frame reset on 4x4: 37 junk beats, reset, then one fresh average frame
    for (int i = 0; i < 16; i++) r_px[i] = 8'($urandom_range(0, 200) - 100);
    for (int j = 0; j < 4; j++) begin
      idx = (j / 2) * 8 + (j % 2) * 2;
      r_exp[j] = pool_px(64'(r_px[idx]), 64'(r_px[idx+1]), 64'(r_px[idx+4]),
                         64'(r_px[idx+5]), 1'b1, 1);
    end
    for (int b = 0; b < 37; b++) begin
      @(posedge clk); #1;
      r_iv = 1'b1; r_id = 8'd127; r_mode = 1'b0;
    end
    @(posedge clk); #1;
    r_iv = 1'b0;
    rst  = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk); #1;
      r_iv   = (cyc < 16);
      r_mode = (cyc == 0);
      if (cyc < 16) r_id = r_px[cyc];
      @(negedge clk);
      if (r_ov && r_or) begin
        if (n < 4) begin
          chk("r_out", 64'(r_od), r_exp[n]);
          chk("r_frame_done", 64'(r_fd), 64'(n == 3));
        end
        n++;
      end
    end
    chk("r_out_count", 64'(n), 64'(4));

    // Randomized: 3 back-to-back 32x32 frames, CH=8, bubbles and backpressure
    fm[0] = 1'b0; fm[1] = 1'b1; fm[2] = 1'($urandom_range(0, 1));
    for (int i = 0; i < 3 * 1024; i++) l_px[i] = {$urandom, $urandom};
    for (int f = 0; f < 3; f++)
      for (int r = 0; r < 32; r += 2)
        for (int c = 0; c < 32; c += 2) begin
          idx = f * 1024 + r * 32 + c;
          e.d = pool_px(l_px[idx], l_px[idx+1], l_px[idx+32], l_px[idx+33], fm[f], 8);
          e.last = (r == 30 && c == 30);
          expq.push_back(e);
        end
    idx = 0; nout = 0; nfd = 0; since = 0;
    for (int cyc = 0; cyc < 40000 && (idx < 3072 || nout < 768); cyc++) begin
      @(posedge clk); #1;
      if (idx < 3072) begin
        l_iv   = ($urandom_range(0, 3) != 0);
        l_id   = l_iv ? l_px[idx] : {$urandom, $urandom};
        l_mode = (idx % 1024 == 0) ? fm[idx / 1024] : 1'($urandom_range(0, 1));
      end else begin
        l_iv = 1'b0;
      end
      l_or = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (l_ov && l_or) begin
        if (expq.size() == 0) begin
          chk("l_extra_output", 64'(1), 64'(0));
        end else begin
          e = expq.pop_front();
          chk("l_out", l_od, e.d);
          chk("l_frame_done", 64'(l_fd), 64'(e.last));
          since++;
          if (e.last) begin
            chk("l_frame_count", 64'(since), 64'(256));
            since = 0;
          end
        end
        if (l_fd) nfd++;
        nout++;
      end else if (l_fd) begin
        chk("l_fd_spurious", 64'(l_fd), 64'(0));
      end
      if (l_iv && l_ir) idx++;
    end
    chk("l_beats", 64'(idx), 64'(3072));
    chk("l_outputs", 64'(nout), 64'(768));
    chk("l_frames", 64'(nfd), 64'(3));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pool2x2_stream.md
POOL2X2_STREAM -- requirements
Module: pool2x2_stream

Interface
- REQ-001: Parameter CH, default 8, number of channels packed per pixel beat.
- REQ-002: Parameter DW, default 8, bits per channel; two's-complement signed.
- REQ-003: Parameter IMG_W, default 32, frame width in pixels; must be even and at least 2.
- REQ-004: Parameter IMG_H, default 32, frame height in rows; must be even and at least 2.
- REQ-005: clk, input, 1, single clock; all logic on its rising edge.
- REQ-006: rst, input, 1, synchronous active-high reset.
- REQ-007: pool_mode, input, 1, pooling mode: 0 = max, 1 = average; sampled per frame.
- REQ-008: in_valid, input, 1, input beat valid.
- REQ-009: in_ready, output, 1, block can accept an input beat.
- REQ-010: in_data, input, CH*DW, one pixel in raster order; channel i occupies bits [(i+1)*DW-1 -: DW].
- REQ-011: out_valid, output, 1, pooled pixel valid.
- REQ-012: out_ready, input, 1, downstream accepts the pooled pixel.
- REQ-013: out_data, output, CH*DW, pooled pixel; same channel packing as in_data.
- REQ-014: frame_done, output, 1, one-cycle pulse when the last pooled pixel of a frame is accepted downstream.

Function
- REQ-015: An input beat transfers when in_valid and in_ready are both 1; an output beat transfers when out_valid and out_ready are both 1.
- REQ-016: in_ready = !out_valid || out_ready (combinational); no other stall source.
- REQ-017: col counter (0..IMG_W-1) and row counter (0..IMG_H-1) advance once per accepted input beat.
  - col wraps at IMG_W-1 and increments row.
  - row wraps at IMG_H-1 to 0, which starts a new frame.
- REQ-018: FSM has two states, EVEN_ROW and ODD_ROW.
  - Reset enters EVEN_ROW.
  - State toggles on acceptance of the beat with col = IMG_W-1.
- REQ-019: On accepting a beat with col even, the block stores in_data in a holding register.
- REQ-020: On accepting a beat with col odd, the block forms a per-channel horizontal result h from the holding register and in_data.
  - Max mode: h is the signed maximum.
  - Average mode: h is the signed sum, DW+1 bits.
- REQ-021: In EVEN_ROW, h is written to line-buffer entry col/2.
  - Line buffer depth is IMG_W/2.
  - Entry width is CH*(DW+1).
- REQ-022: In ODD_ROW, h is combined with line-buffer entry col/2.
  - Max mode: result is the signed maximum of the two.
  - Average mode: the DW+2-bit sum is arithmetically shifted right by 2 (floor).
  - The result is registered into out_data, and out_valid is set in the following cycle (latency 1 cycle from the accepting edge).
- REQ-023: In max mode, a comparison with equal operands selects either operand; the result value is identical.
- REQ-024: out_valid clears on an output transfer unless a new result is loaded on the same edge, in which case it stays 1 and out_data is updated.
- REQ-025: out_data holds its value while out_valid=1 and out_ready=0.
- REQ-026: pool_mode is latched when the beat with row=0 and col=0 is accepted; the latched value governs the whole frame.
- REQ-027: The output order is raster order over the (IMG_W/2)x(IMG_H/2) pooled grid.
- REQ-028: frame_done pulses for one cycle on the output transfer of the pooled pixel produced from row IMG_H-1, col IMG_W-1.
- REQ-029: in_valid=0 bubbles at any position do not alter counters, state or stored data.

Reset
- REQ-030: On rst=1 at a clock edge, the following are cleared:
  - out_valid = 0, out_data = 0, frame_done = 0;
  - col = 0, row = 0, state = EVEN_ROW;
  - the latched mode = 0 (max).
- REQ-031: Line-buffer and holding-register contents are don't-care after reset; no output may depend on them before they are rewritten.
- REQ-032: Reset asserted mid-frame discards the partial frame; the next accepted beat is treated as row 0, col 0.
- REQ-033: in_ready is 1 in the cycle following reset.

Verification
- REQ-034: CH=1, DW=8, IMG_W=IMG_H=2, max mode, input 3, -5, 7, -128 -> one output, 7, one cycle after the 4th beat; frame_done pulses on its acceptance.
- REQ-035: Same frame in average mode (3, -5, 7, -128) -> output -31 (sum -123, floor of -30.75); inputs 127, 127, 127, 127 -> output 127 with no overflow.
- REQ-036: IMG_W=4, IMG_H=2, out_ready held 0 after the first output -> in_ready drops, out_data is stable, no beat is lost; releasing out_ready yields the second output next.
- REQ-037: Random in_valid bubbles and random out_ready over 3 back-to-back 32x32 frames, CH=8, both modes -> output stream matches the reference model; exactly 256 outputs and one frame_done per frame.
- REQ-038: rst asserted after 37 beats of a 4x4 frame, then a full fresh frame -> exactly 4 outputs, all derived only from post-reset data.
- REQ-039: pool_mode toggled mid-frame -> the current frame uses the mode latched at its first beat; the new mode takes effect at the next frame.
